aes_ecb_encrypt: RTL and testbench

AES-128 encryption engine for Electronic Codebook (ECB) mode. Each 128-bit plaintext block is encrypted independently under a 128-bit key. The datapath is iterative: one round per clock, with the key schedule expanded on the fly. Blocks are streamed in and out through valid/ready handshakes and grouped into frames of NUM_BLOCKS blocks for the downstream buffer.

---
 rtl/aes_ecb_encrypt.sv | 210 +++++++++++++++++++++
 tb/tb_aes_ecb_encrypt.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_encrypt.sv
// AES-128 ECB encryption engine: one round per clock, on-the-fly key expansion, frame marking.
// Optional macro AES_ECB_FRAME_CNT_EN adds the frame_idx output port.
module aes_ecb_encrypt #(
    parameter int NUM_BLOCKS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         out_last
`ifdef AES_ECB_FRAME_CNT_EN
    ,
    output logic [15:0]  frame_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_BLOCKS - 1);

    // Forward S-box, byte 0x00 in the top 8 bits of the table.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TAB[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return res;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(r+4*c) -: 8] = get_byte(s, r + 4*((c + r) % 4));
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c + 1);
            a2 = get_byte(s, 4*c + 2);
            a3 = get_byte(s, 4*c + 3);
            res[127-32*c -: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            res[127-32*c-8 -: 8]    = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            res[127-32*c-16 -: 8]   = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            res[127-32*c-24 -: 8]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return res;
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] out_block_q, out_block_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;

    logic [127:0] round_key_next;
    logic [127:0] sub_shift;
    logic [127:0] round_out;

    assign round_key_next = next_round_key(rkey_q, rcon(round_q));
    assign sub_shift      = shift_rows(sub_bytes(data_q));
    assign round_out      = ((round_q == 4'd10) ? sub_shift : mix_columns(sub_shift)) ^ round_key_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rkey_q      <= '0;
            round_q     <= '0;
            out_block_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rkey_q      <= rkey_d;
            round_q     <= round_d;
            out_block_q <= out_block_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rkey_d      = rkey_q;
        round_d     = round_q;
        out_block_d = out_block_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_block ^ in_key;
                    rkey_d  = in_key;
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d  = round_out;
                rkey_d  = round_key_next;
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    out_block_d = round_out;
                    round_d     = 4'd0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    frame_cnt_d = (frame_cnt_q == LAST_IDX) ? 16'd0 : frame_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_block = out_block_q;
    assign out_last  = (state_q == DONE) && (frame_cnt_q == LAST_IDX);

`ifdef AES_ECB_FRAME_CNT_EN
    assign frame_idx = frame_cnt_q;
`endif

endmodule

// File: tb/tb_aes_ecb_encrypt.sv
// Self-checking bench for aes_ecb_encrypt: known-answer vectors plus random blocks against a
// GF(2^8)-arithmetic AES-128 model; also exercises backpressure, mid-block reset and frame wrap.
module tb_aes_ecb_encrypt;

    localparam int NUM_BLOCKS = 64;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         out_last;
`ifdef AES_ECB_FRAME_CNT_EN
    logic [15:0]  frame_idx;
`endif

    int          checks = 0;
    int          errors = 0;
    int          latency;
    int          expCount = 0;
    logic [7:0]  sboxT [256];

    always #5 clk = ~clk;

    aes_ecb_encrypt #(.NUM_BLOCKS(NUM_BLOCKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_last  (out_last)
`ifdef AES_ECB_FRAME_CNT_EN
        ,
        .frame_idx (frame_idx)
`endif
    );

    // Reference model built from field arithmetic rather than lookup tables.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sboxCalc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aesModel(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rk [176];
        logic [7:0]   t [4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) rk[i] = key[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                a0 = t[0];
                t[0] = sboxT[t[1]] ^ rc;
                t[1] = sboxT[t[2]];
                t[2] = sboxT[t[3]];
                t[3] = sboxT[a0];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sboxT[st[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    st[row + 4*c] = tmp[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r + i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Accepts one block, then scrambles the inputs so a late key sample would show up.
    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check1("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_block = pt;
        in_key   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_key   = ~key;
        in_block = {$urandom, $urandom, $urandom, $urandom};
        latency  = 0;
        while (latency < 40) begin
            @(posedge clk); #1;
            latency++;
            if (out_valid) break;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] exp);
        check32({tag, "_latency"}, latency, 10);
        check128({tag, "_block"}, out_block, exp);
        check1({tag, "_last"}, out_last, (expCount == NUM_BLOCKS - 1));
        check1({tag, "_in_ready_busy"}, in_ready, 1'b0);
`ifdef AES_ECB_FRAME_CNT_EN
        check32({tag, "_frame_idx"}, int'(frame_idx), expCount);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1({tag, "_valid_drop"}, out_valid, 1'b0);
        check1({tag, "_in_ready_back"}, in_ready, 1'b1);
        expCount = (expCount + 1) % NUM_BLOCKS;
    endtask

    initial begin
        logic [127:0] rk;
        logic [127:0] rp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        in_key    = '0;
        for (int i = 0; i < 256; i++) sboxT[i] = sboxCalc(8'(i));

        repeat (2) @(posedge clk);
        #1;
        check1("reset_in_ready", in_ready, 1'b1);
        check1("reset_out_valid", out_valid, 1'b0);
        check1("reset_out_last", out_last, 1'b0);
        check128("reset_out_block", out_block, 128'h0);
`ifdef AES_ECB_FRAME_CNT_EN
        check32("reset_frame_idx", int'(frame_idx), 0);
`endif
        rst = 1'b0;

        $display("[TB] known-answer vectors");
        applyStimulus(C1_KEY, C1_PT);
        checkOutput("fips_c1", C1_CT);
        applyStimulus(B_KEY, B_PT);
        checkOutput("fips_b", B_CT);
        applyStimulus(128'h0, 128'h0);
        checkOutput("all_zero", ZERO_CT);

        $display("[TB] alternating blocks, no chaining");
        for (int i = 0; i < 4; i++) begin
            rp = (i % 2 == 0) ? C1_PT : 128'h0;
            applyStimulus(C1_KEY, rp);
            checkOutput("alternate", aesModel(C1_KEY, rp));
        end

        $display("[TB] backpressure hold");
        applyStimulus(C1_KEY, C1_PT);
        repeat (20) @(posedge clk);
        #1;
        check128("hold_block", out_block, C1_CT);
        check1("hold_valid", out_valid, 1'b1);
        check1("hold_in_ready", in_ready, 1'b0);
        checkOutput("hold_release", C1_CT);

        $display("[TB] random blocks against model");
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rk, rp);
            checkOutput("random", aesModel(rk, rp));
        end

        $display("[TB] reset during round 5");
        in_valid = 1'b1;
        in_block = C1_PT;
        in_key   = C1_KEY;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expCount = 0;
        check1("abort_out_valid", out_valid, 1'b0);
        check1("abort_in_ready", in_ready, 1'b1);
        check128("abort_out_block", out_block, 128'h0);
        repeat (12) @(posedge clk);
        #1;
        check1("abort_no_output", out_valid, 1'b0);
        applyStimulus(C1_KEY, C1_PT);
        checkOutput("after_abort", C1_CT);

        $display("[TB] frame of %0d blocks plus wrap", NUM_BLOCKS);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expCount = 0;
        for (int i = 0; i < NUM_BLOCKS + 1; i++) begin
            applyStimulus(C1_KEY, C1_PT);
            checkOutput("frame", C1_CT);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
